// File: rtl/pc_pkg.sv
// pc_pkg: shared types and helpers for the pc_ras program counter.
//   op_t   - the single operation taken on a clock edge
//   pc_op  - fixed-priority encode of the decoder strobes to op_t
//   DEFAULT_WIDTH / DEFAULT_DEPTH - default PC width and RAS depth
package pc_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned DEFAULT_DEPTH = 8;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_INC,
        OP_REL,
        OP_RET,
        OP_CALL,
        OP_LOAD
    } op_t;

    // Priority: load > call > ret > rel > inc > hold.
    function automatic op_t pc_op(input logic load, input logic call,
                                  input logic ret, input logic rel,
                                  input logic inc);
        if (load)      return OP_LOAD;
        else if (call) return OP_CALL;
        else if (ret)  return OP_RET;
        else if (rel)  return OP_REL;
        else if (inc)  return OP_INC;
        else           return OP_HOLD;
    endfunction

endpackage

// File: rtl/pc_ras_stack.sv
// pc_ras_stack: LIFO return-address stack indexed by its occupancy.
//   clk, reset   - clock, asynchronous active-high reset (empties the stack)
//   i_push       - write i_data at slot sp and increment sp (ignored when full)
//   i_pop        - decrement sp (ignored when empty); push wins if both set
//   i_data       - value to push
//   o_top_c      - entry at sp-1 (combinational read of registered state, 0 when empty)
//   o_sp         - occupancy 0..DEPTH
//   o_full       - sp == DEPTH
//   o_empty      - sp == 0
module pc_ras_stack
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_data,
    output logic [WIDTH-1:0]           o_top_c,
    output logic [$clog2(DEPTH+1)-1:0] o_sp,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int unsigned SPW = $clog2(DEPTH + 1);
    localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned NE  = 2 ** AW;

    logic [WIDTH-1:0] r_mem [NE];
    logic [SPW-1:0]   r_sp;
    logic             r_full;
    logic             r_empty;
    logic [SPW-1:0]   w_sp_next;
    logic             w_do_push;
    logic             w_do_pop;

    // Next occupancy; saturating at both ends.
    always_comb begin
        w_do_push = i_push && !r_full;
        w_do_pop  = i_pop && !r_empty && !i_push;
        w_sp_next = r_sp;
        if (w_do_push)     w_sp_next = r_sp + SPW'(1);
        else if (w_do_pop) w_sp_next = r_sp - SPW'(1);
    end

    // Occupancy and flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sp    <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            r_sp    <= w_sp_next;
            r_full  <= (w_sp_next == SPW'(DEPTH));
            r_empty <= (w_sp_next == '0);
        end
    end

    // Storage needs no reset; contents are meaningless while empty.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[AW'(r_sp)] <= i_data;
    end

    assign o_top_c = r_empty ? '0 : r_mem[AW'(r_sp - SPW'(1))];
    assign o_sp    = r_sp;
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/pc_ras.sv
// pc_ras: program counter with load, increment, PC-relative branch and a
// hardware return-address stack for call/return.
//   clk, reset - clock, asynchronous active-high reset (PC=RESET_VEC, RAS empty)
//   in         - absolute target (load/call) or signed offset (rel)
//   load/call/ret/rel/inc - strobes, priority load > call > ret > rel > inc
//   out        - current PC
//   sp         - RAS occupancy; empty/full flags
//   ovf/unf    - one-cycle pulses for call-while-full / ret-while-empty
//   err        - only with PC_RAS_TRAP_EN: sticky trap on ovf/unf that
//                freezes PC and RAS until reset
module pc_ras
    import pc_pkg::*;
#(
    parameter int unsigned     WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned     DEPTH     = DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           in,
    input  logic                       load,
    input  logic                       call,
    input  logic                       ret,
    input  logic                       rel,
    input  logic                       inc,
    output logic [WIDTH-1:0]           out,
    output logic [$clog2(DEPTH+1)-1:0] sp,
    output logic                       empty,
    output logic                       full,
`ifdef PC_RAS_TRAP_EN
    output logic                       err,
`endif
    output logic                       ovf,
    output logic                       unf
);

    logic [WIDTH-1:0] r_pc;
    logic             r_ovf;
    logic             r_unf;
    logic [WIDTH-1:0] w_pc_next;
    logic [WIDTH-1:0] w_pc_inc;
    logic [WIDTH-1:0] w_top;
    logic             w_push;
    logic             w_pop;
    logic             w_ovf;
    logic             w_unf;
    logic             w_freeze;
    op_t              w_op;

`ifdef PC_RAS_TRAP_EN
    logic r_err;

    // Sticky trap: set by any overflow/underflow event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_err <= 1'b0;
        else       r_err <= r_err | w_ovf | w_unf;
    end

    assign w_freeze = r_err;
    assign err      = r_err;
`else
    assign w_freeze = 1'b0;
`endif

    // Operation select and next-PC / stack control.
    always_comb begin
        w_pc_inc  = r_pc + WIDTH'(1);
        w_op      = w_freeze ? OP_HOLD : pc_op(load, call, ret, rel, inc);
        w_pc_next = r_pc;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_ovf     = 1'b0;
        w_unf     = 1'b0;
        unique case (w_op)
            OP_LOAD: w_pc_next = in;
            OP_CALL: begin
                w_pc_next = in;
                w_push    = !full;
                w_ovf     = full;
            end
            OP_RET: begin
                w_pc_next = empty ? RESET_VEC : w_top;
                w_pop     = !empty;
                w_unf     = empty;
            end
            OP_REL:  w_pc_next = r_pc + in;
            OP_INC:  w_pc_next = w_pc_inc;
            default: w_pc_next = r_pc;
        endcase
    end

    // PC and event pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc  <= RESET_VEC;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_pc  <= w_pc_next;
            r_ovf <= w_ovf;
            r_unf <= w_unf;
        end
    end

    pc_ras_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_pc_inc),
        .o_top_c (w_top),
        .o_sp    (sp),
        .o_full  (full),
        .o_empty (empty)
    );

    assign out = r_pc;
    assign ovf = r_ovf;
    assign unf = r_unf;

endmodule
